// File: rtl/dfadd_result_serializer.sv
// Buffers dfadd results in a small FIFO and streams each word LSB-first to a viterbi encoder lane.
// Optional SERIALIZER_PARITY_EN appends an even-parity bit after each word.
module dfadd_result_serializer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              finish_i,
    input  logic [DATA_W-1:0] result_i,
    output logic              encoder_o,
    output logic              enable_encoder_o,
    output logic              busy_o,
    output logic              overflow_o,
    output logic [7:0]        words_sent_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef SERIALIZER_PARITY_EN
    localparam int unsigned WORD_BITS = DATA_W + 1;
`else
    localparam int unsigned WORD_BITS = DATA_W;
`endif
    localparam int unsigned BIT_W = $clog2(WORD_BITS + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty, fifo_full, push, pop;
    logic [DATA_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              last_bit, gap_done;
    logic              enc_d, en_d, busy_d;
    logic              enc_q, en_q, busy_q, overflow_q;
    logic [7:0]        words_sent_q;
`ifdef SERIALIZER_PARITY_EN
    logic              par_q;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign last_bit   = (bit_cnt == BIT_W'(1));
    assign gap_done   = (gap_cnt == GAP_W'(1));
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push       = !rst && finish_i && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (GAP_CYCLES > 0) state_next = GAP;
                    else if (!fifo_empty) pop = 1'b1;
                    else state_next = IDLE;
                end
            end
            GAP: begin
                if (gap_done) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        enc_d  = 1'b0;
        en_d   = 1'b0;
        busy_d = (state != IDLE) || !fifo_empty;
        if (state == SHIFT) begin
            en_d  = 1'b1;
            enc_d = shreg[0];
`ifdef SERIALIZER_PARITY_EN
            if (last_bit) enc_d = par_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= result_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            enc_q        <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            words_sent_q <= '0;
`ifdef SERIALIZER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (finish_i && !push) overflow_q <= 1'b1;

            if (pop) begin
                shreg   <= mem[rd_ptr];
                bit_cnt <= BIT_W'(WORD_BITS);
`ifdef SERIALIZER_PARITY_EN
                par_q   <= ^mem[rd_ptr];
`endif
            end else if (state == SHIFT) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt - 1'b1;
            end

            if (state != GAP && state_next == GAP) gap_cnt <= GAP_W'(GAP_CYCLES);
            else if (state == GAP)                 gap_cnt <= gap_cnt - 1'b1;

            if (state == SHIFT && last_bit) words_sent_q <= words_sent_q + 8'd1;

            enc_q  <= enc_d;
            en_q   <= en_d;
            busy_q <= busy_d;
        end
    end

    assign encoder_o        = enc_q;
    assign enable_encoder_o = en_q;
    assign busy_o           = busy_q;
    assign overflow_o       = overflow_q;
    assign words_sent_o     = words_sent_q;

endmodule

// File: tb/tb_dfadd_result_serializer.sv
// Self-checking bench: two serializers (gap 2 and gap 0) share stimulus and are
// compared every cycle against a pop-schedule reference model.
module tb_dfadd_result_serializer;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
`ifdef SERIALIZER_PARITY_EN
    localparam int WB = DW + 1;
`else
    localparam int WB = DW;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        finish_i;
    logic [31:0] result_i;
    logic        enc [2];
    logic        en  [2];
    logic        busy[2];
    logic        ovf [2];
    logic [7:0]  ws  [2];

    dfadd_result_serializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .finish_i(finish_i), .result_i(result_i),
        .encoder_o(enc[0]), .enable_encoder_o(en[0]), .busy_o(busy[0]),
        .overflow_o(ovf[0]), .words_sent_o(ws[0])
    );

    dfadd_result_serializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .finish_i(finish_i), .result_i(result_i),
        .encoder_o(enc[1]), .enable_encoder_o(en[1]), .busy_o(busy[1]),
        .overflow_o(ovf[1]), .words_sent_o(ws[1])
    );

    always #5 clk = ~clk;

    // Reference model: a word popped at edge k shows its bits after edges k+1..k+WB,
    // and the next pop may happen no earlier than edge k+WB+gap.
    logic [31:0] mq[2][$];
    logic [31:0] cur_w [2];
    int          cur_k [2];
    int          free_e[2];
    logic [7:0]  ws_exp[2];
    logic        ovf_exp[2];
    int          cyc;
    int          checks;
    int          errors;
    int          en_cnt[2];
    int          first_hi[2];
    int          last_hi[2];
    logic        last_bit_seen[2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d] cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            cur_w[i]   = '0;
            cur_k[i]   = -100000;
            free_e[i]  = 0;
            ws_exp[i]  = '0;
            ovf_exp[i] = 1'b0;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            en_cnt[i]        = 0;
            first_hi[i]      = -1;
            last_hi[i]       = -1;
            last_bit_seen[i] = 1'b0;
        end
    endtask

    task automatic model_edge_and_check(input logic fin, input logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            int   sz;
            int   idx;
            bit   popped;
            logic exp_en, exp_bit, exp_busy;
            sz       = mq[i].size();
            exp_busy = ((cyc - 1) >= cur_k[i] && (cyc - 1) < cur_k[i] + WB + gap_of(i)) || (sz > 0);
            exp_en   = 1'b0;
            exp_bit  = 1'b0;
            if (cyc >= cur_k[i] + 1 && cyc <= cur_k[i] + WB) begin
                exp_en = 1'b1;
                idx    = cyc - cur_k[i] - 1;
                exp_bit = (idx < DW) ? cur_w[i][idx] : ^cur_w[i];
            end
            if (cyc == cur_k[i] + WB) ws_exp[i] = ws_exp[i] + 8'd1;
            popped = (sz > 0) && (cyc >= free_e[i]);
            if (popped) begin
                cur_w[i]  = mq[i].pop_front();
                cur_k[i]  = cyc;
                free_e[i] = cyc + WB + gap_of(i);
            end
            if (fin) begin
                if (sz < DEPTH || popped) mq[i].push_back(d);
                else ovf_exp[i] = 1'b1;
            end
            chk("enable",     i, {31'b0, en[i]},   {31'b0, exp_en});
            chk("encoder",    i, {31'b0, enc[i]},  {31'b0, exp_bit});
            chk("busy",       i, {31'b0, busy[i]}, {31'b0, exp_busy});
            chk("overflow",   i, {31'b0, ovf[i]},  {31'b0, ovf_exp[i]});
            chk("words_sent", i, {24'b0, ws[i]},   {24'b0, ws_exp[i]});
            if (en[i] === 1'b1) begin
                en_cnt[i]++;
                if (first_hi[i] < 0) first_hi[i] = cyc;
                last_hi[i]       = cyc;
                last_bit_seen[i] = enc[i];
            end
        end
    endtask

    task automatic step(input logic fin, input logic [31:0] d);
        finish_i = fin;
        result_i = d;
        @(posedge clk);
        #1;
        cyc++;
        model_edge_and_check(fin, d);
        finish_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, $urandom);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        finish_i = 1'($urandom_range(0, 1));
        result_i = $urandom;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst      = 1'b0;
        finish_i = 1'b0;
        model_reset();
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            chk("rst_enable",     i, {31'b0, en[i]},   32'd0);
            chk("rst_encoder",    i, {31'b0, enc[i]},  32'd0);
            chk("rst_busy",       i, {31'b0, busy[i]}, 32'd0);
            chk("rst_overflow",   i, {31'b0, ovf[i]},  32'd0);
            chk("rst_words_sent", i, {24'b0, ws[i]},   32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   p;
        logic exp_last;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        finish_i = 1'b0;
        result_i = '0;
        model_reset();
        clear_counts();

        // Reset then idle.
        do_reset(3);
        idle(10);
        for (int i = 0; i < 2; i++) chk("idle_busy", i, {31'b0, busy[i]}, 32'd0);

        // Single word 0x5.
        do_reset(1);
        step(1'b1, 32'h0000_0005);
        idle(45);
        for (int i = 0; i < 2; i++) begin
            chk("single_en_count", i, 32'(en_cnt[i]), 32'(WB));
            chk("single_words",    i, {24'b0, ws[i]}, 32'd1);
        end

        // Four back-to-back captures into a 2-deep FIFO: the fourth is dropped.
        do_reset(1);
        for (int k = 0; k < 4; k++) step(1'b1, $urandom);
        idle(3 * (WB + 2) + 10);
        for (int i = 0; i < 2; i++) begin
            chk("burst_overflow", i, {31'b0, ovf[i]}, 32'd1);
            chk("burst_words",    i, {24'b0, ws[i]},  32'd3);
        end

        // All ones then all zeros: contiguous on the zero-gap instance.
        do_reset(1);
        step(1'b1, 32'hFFFF_FFFF);
        step(1'b1, 32'h0000_0000);
        idle(2 * WB + 15);
        chk("b2b_en_count", 1, 32'(en_cnt[1]), 32'(2 * WB));
        chk("b2b_span",     1, 32'(last_hi[1] - first_hi[1] + 1), 32'(2 * WB));
        chk("b2b_words",    1, {24'b0, ws[1]}, 32'd2);

        // Reset while bit 10 of 0xDEADBEEF is on the wire.
        do_reset(1);
        step(1'b1, 32'hDEAD_BEEF);
        idle(12);
        do_reset(1);
        idle(40);
        for (int i = 0; i < 2; i++) chk("midrst_en_count", i, 32'(en_cnt[i]), 32'd0);

        // Word 0x7: final bit is parity (1) when enabled, else data bit 31 (0).
`ifdef SERIALIZER_PARITY_EN
        exp_last = 1'b1;
`else
        exp_last = 1'b0;
`endif
        do_reset(1);
        step(1'b1, 32'h0000_0007);
        idle(45);
        for (int i = 0; i < 2; i++) begin
            chk("seven_en_count", i, 32'(en_cnt[i]), 32'(WB));
            chk("seven_last_bit", i, {31'b0, last_bit_seen[i]}, {31'b0, exp_last});
        end

        // Randomized traffic with varying load and occasional mid-stream resets.
        do_reset(1);
        for (int k = 0; k < 3000; k++) begin
            p = (k < 1500) ? 3 : 12;
            if ($urandom_range(0, 499) == 0) do_reset(1);
            else step(1'($urandom_range(0, 99) < p), $urandom);
        end
        idle(3 * (WB + 2) + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
